// File: rtl/add_pkg.sv
// Shared definitions for the add_accum16 accumulator slice.
//   ADD_WIDTH : default operand / sum width in bits
//   ADD_CNT_W : default width of the operand-count field
//   state_e   : accumulator control states
package add_pkg;

    localparam int unsigned ADD_WIDTH = 16;
    localparam int unsigned ADD_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage : add_pkg

// File: rtl/add16_rc.sv
// WIDTH-bit ripple-carry adder.
// Ports:
//   sum  : a + b + cin, truncated to WIDTH bits
//   cout : carry out of the most significant bit
//   a, b : operands
//   cin  : carry in
module add16_rc
    import add_pkg::*;
#(
    parameter int unsigned WIDTH = ADD_WIDTH
) (
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin
);

    logic carry;

    // Bit-serial carry chain, LSB first.
    always_comb begin
        carry = cin;
        sum   = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule : add16_rc

// File: rtl/add_accum16.sv
// Streaming accumulator: sums `len` operands accepted on a valid/ready
// input and presents the sum plus a sticky carry-out flag on a
// valid/ready output.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, len          : begin a run of len operands (sampled in IDLE)
//   in_valid/in_ready   : operand handshake, in_data is the operand
//   out_valid/out_ready : result handshake
//   out_sum, out_ovf    : live accumulator and sticky carry-out
//   busy                : high whenever not IDLE
// Build option: define ADD_ACCUM_SAT_EN to saturate the accumulator at
// all ones on carry-out instead of wrapping modulo 2^WIDTH.
module add_accum16
    import add_pkg::*;
#(
    parameter int unsigned WIDTH = ADD_WIDTH,
    parameter int unsigned CNT_W = ADD_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    output logic             busy
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;

    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;

    // Single shared adder: accumulator plus incoming operand.
    add16_rc #(
        .WIDTH (WIDTH)
    ) u_add (
        .sum  (add_sum),
        .cout (add_cout),
        .a    (acc_q),
        .b    (in_data),
        .cin  (1'b0)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    if (len != '0) begin
                        cnt_d   = len;
                        state_d = ACCUM;
                    end else begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end
                end
            end

            ACCUM: begin
                if (in_valid) begin
`ifdef ADD_ACCUM_SAT_EN
                    // Once saturated, any further add either carries or adds
                    // zero, so the accumulator stays pinned at all ones.
                    acc_d = add_cout ? '1 : add_sum;
`else
                    acc_d = add_sum;
`endif
                    ovf_d = ovf_q | add_cout;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= (state_d == ACCUM);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;

endmodule : add_accum16
